// File: rtl/main_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : main_host_sequencer
//  Purpose  : Host-side initiator for the main command/in/out stream protocol.
//             Sends one command word, then concurrently streams a programmed
//             number of 64-bit words src->in and out->sink with zero-latency
//             pass-through (no buffering), then pulses done.
//  Ports    : clk, rst (async active-low)
//             start/start_cmd/in_words/out_words : transaction request
//             busy/done                          : transaction status
//             cmd/cmd_isReady/cmd_canReceive     : command channel to main
//             in/in_isReady/in_canReceive        : data channel to main
//             out/out_isReady/out_canReceive     : data channel from main
//             src_*                              : word source
//             sink_*                             : word sink
//  Revision : 1.0 - initial release
// ============================================================================
module main_host_sequencer #(
   parameter int CMD_W      = 8,
   parameter int CNT_W      = 14,
   parameter bit SWAP_BYTES = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CMD_W-1:0] start_cmd,
   input  logic [CNT_W-1:0] in_words,
   input  logic [CNT_W-1:0] out_words,
   output logic             busy,
   output logic             done,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_isReady,
   input  logic             cmd_canReceive,
   output logic [63:0]      in,
   output logic             in_isReady,
   input  logic             in_canReceive,
   input  logic [63:0]      out,
   input  logic             out_isReady,
   output logic             out_canReceive,
   input  logic [63:0]      src_data,
   input  logic             src_isReady,
   output logic             src_canReceive,
   output logic [63:0]      sink_data,
   output logic             sink_isReady,
   input  logic             sink_canReceive
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CMD    = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state;
   logic [CMD_W-1:0] cmd_q;
   logic [CNT_W-1:0] in_rem;
   logic [CNT_W-1:0] out_rem;

   logic streaming;
   logic in_pending;
   logic out_pending;
   logic in_xfer;
   logic out_xfer;

   assign streaming   = (state == S_STREAM);
   assign in_pending  = (in_rem != '0);
   assign out_pending = (out_rem != '0);

   // Handshakes are pure pass-through gated by the remaining count, so the
   // two directions progress independently and main can never deadlock.
   assign in_isReady     = streaming & src_isReady & in_pending;
   assign src_canReceive = streaming & in_canReceive & in_pending;
   assign sink_isReady   = streaming & out_isReady & out_pending;
   assign out_canReceive = streaming & sink_canReceive & out_pending;

   assign in_xfer  = in_isReady & in_canReceive;
   assign out_xfer = sink_isReady & sink_canReceive;

   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign cmd_isReady = (state == S_CMD);
   assign cmd         = cmd_q;

   generate
      if (SWAP_BYTES) begin : g_swap
         for (genvar k = 0; k < 8; k++) begin : g_byte
            assign in[8*k +: 8]        = src_data[8*(7-k) +: 8];
            assign sink_data[8*k +: 8] = out[8*(7-k) +: 8];
         end
      end else begin : g_noswap
         assign in        = src_data;
         assign sink_data = out;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cmd_q   <= '0;
         in_rem  <= '0;
         out_rem <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cmd_q   <= start_cmd;
                  in_rem  <= in_words;
                  out_rem <= out_words;
                  state   <= S_CMD;
               end
            end
            S_CMD: begin
               if (cmd_canReceive) begin
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               // Completion is judged on the registered counts, so the edge
               // that consumes the last word is followed by one more cycle.
               if (!in_pending && !out_pending) begin
                  state <= S_DONE;
               end else begin
                  if (in_xfer) begin
                     in_rem <= in_rem - CNT_W'(1);
                  end
                  if (out_xfer) begin
                     out_rem <= out_rem - CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_main_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_host_sequencer
//  Purpose  : Self-checking bench for main_host_sequencer. Random handshake
//             stalls are checked against a transaction-level reference model
//             (phase, words remaining, word sequence numbers).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_host_sequencer;

   localparam int CMD_W = 8;
   localparam int CNT_W = 14;
   localparam logic [63:0] SRC_BASE = 64'h0102030405060708;
   localparam logic [63:0] OUT_BASE = 64'h1122334455667788;
   localparam int P_IDLE = 0, P_CMD = 1, P_STREAM = 2, P_DONE = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CMD_W-1:0] start_cmd;
   logic [CNT_W-1:0] in_words;
   logic [CNT_W-1:0] out_words;
   logic             busy;
   logic             done;
   logic [CMD_W-1:0] cmd;
   logic             cmd_isReady;
   logic             cmd_canReceive;
   logic [63:0]      in;
   logic             in_isReady;
   logic             in_canReceive;
   logic [63:0]      out;
   logic             out_isReady;
   logic             out_canReceive;
   logic [63:0]      src_data;
   logic             src_isReady;
   logic             src_canReceive;
   logic [63:0]      sink_data;
   logic             sink_isReady;
   logic             sink_canReceive;

   main_host_sequencer #(.CMD_W(CMD_W), .CNT_W(CNT_W), .SWAP_BYTES(1'b1)) dut (
      .clk(clk), .rst(rst),
      .start(start), .start_cmd(start_cmd), .in_words(in_words), .out_words(out_words),
      .busy(busy), .done(done),
      .cmd(cmd), .cmd_isReady(cmd_isReady), .cmd_canReceive(cmd_canReceive),
      .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
      .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
      .src_data(src_data), .src_isReady(src_isReady), .src_canReceive(src_canReceive),
      .sink_data(sink_data), .sink_isReady(sink_isReady), .sink_canReceive(sink_canReceive)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model
   int          phase = P_IDLE;
   int          in_left = 0, out_left = 0;
   int          in_sent = 0, out_sent = 0;
   int          cmd_wait = 0;
   logic [7:0]  exp_cmd = 8'h00;

   // stimulus configuration
   int mode = 0;   // 0: random stalls, 1: output-before-input ordering
   int pct  = 0;   // stall probability in percent
   int hold = 0;   // cycles to hold cmd_canReceive low

   // observed DUT activity per transaction
   int act_in, act_out, act_cstall, act_done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] swap_ref(input logic [63:0] x);
      logic [63:0] r;
      r = 64'h0;
      for (int k = 0; k < 8; k++) begin
         r = r | (((x >> (8 * k)) & 64'hFF) << (8 * (7 - k)));
      end
      return r;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_vld"},   64'(in_isReady),     64'h0);
      check({tag, "_src_rdy"},  64'(src_canReceive), 64'h0);
      check({tag, "_sink_vld"}, 64'(sink_isReady),   64'h0);
      check({tag, "_out_rdy"},  64'(out_canReceive), 64'h0);
      check({tag, "_cmd_vld"},  64'(cmd_isReady),    64'h0);
      check({tag, "_busy"},     64'(busy),           64'h0);
      check({tag, "_done"},     64'(done),           64'h0);
      check({tag, "_cmd"},      64'(cmd),            64'h0);
   endtask

   task automatic cycle(input bit st, input logic [7:0] sc, input int si, input int so);
      bit stream, e_in_v, e_src_r, e_sink_v, e_out_r;
      @(negedge clk);
      start     = st;
      start_cmd = sc;
      in_words  = CNT_W'(si);
      out_words = CNT_W'(so);
      src_data  = SRC_BASE + 64'(in_sent);
      out       = OUT_BASE + 64'(out_sent);
      if (phase == P_CMD) cmd_canReceive = (cmd_wait >= hold);
      else                cmd_canReceive = 1'($urandom_range(0, 1));
      if (mode == 0) begin
         src_isReady     = ($urandom_range(0, 99) >= pct);
         in_canReceive   = ($urandom_range(0, 99) >= pct);
         out_isReady     = ($urandom_range(0, 99) >= pct);
         sink_canReceive = ($urandom_range(0, 99) >= pct);
      end else begin
         src_isReady     = 1'b1;
         sink_canReceive = 1'b1;
         out_isReady     = (in_sent >= 1);
         in_canReceive   = (in_sent < 1) || (out_sent >= 2);
      end
      #1;
      stream   = (phase == P_STREAM);
      e_in_v   = stream && src_isReady     && (in_left > 0);
      e_src_r  = stream && in_canReceive   && (in_left > 0);
      e_sink_v = stream && out_isReady     && (out_left > 0);
      e_out_r  = stream && sink_canReceive && (out_left > 0);
      check("busy",     64'(busy),           64'(phase != P_IDLE));
      check("done",     64'(done),           64'(phase == P_DONE));
      check("cmd_vld",  64'(cmd_isReady),    64'(phase == P_CMD));
      check("in_vld",   64'(in_isReady),     64'(e_in_v));
      check("src_rdy",  64'(src_canReceive), 64'(e_src_r));
      check("sink_vld", 64'(sink_isReady),   64'(e_sink_v));
      check("out_rdy",  64'(out_canReceive), 64'(e_out_r));
      if (phase == P_CMD) check("cmd", 64'(cmd), 64'(exp_cmd));
      if (e_in_v) begin
         check("in_data", in, swap_ref(SRC_BASE + 64'(in_sent)));
         if (in_sent == 0) check("in_swap0", in, 64'h0807060504030201);
      end
      if (e_sink_v) begin
         check("sink_data", sink_data, swap_ref(OUT_BASE + 64'(out_sent)));
         if (out_sent == 0) check("sink_swap0", sink_data, 64'h8877665544332211);
      end
      if (in_isReady && in_canReceive)     act_in++;
      if (sink_isReady && sink_canReceive) act_out++;
      if (cmd_isReady && !cmd_canReceive)  act_cstall++;
      if (done)                            act_done++;
      @(posedge clk);
      case (phase)
         P_IDLE: if (st) begin
            phase    = P_CMD;
            exp_cmd  = sc;
            in_left  = si;
            out_left = so;
            in_sent  = 0;
            out_sent = 0;
            cmd_wait = 0;
         end
         P_CMD: begin
            if (cmd_canReceive) phase = P_STREAM;
            else                cmd_wait++;
         end
         P_STREAM: begin
            if (in_left == 0 && out_left == 0) phase = P_DONE;
            else begin
               if (e_in_v && in_canReceive)     begin in_left--;  in_sent++;  end
               if (e_sink_v && sink_canReceive) begin out_left--; out_sent++; end
            end
         end
         default: phase = P_IDLE;
      endcase
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_idle_outputs("rst");
      phase = P_IDLE;
      repeat (2) begin
         @(posedge clk);
         #1 check("rst_done_hold", 64'(done), 64'h0);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_txn(input logic [7:0] c, input int ni, input int no);
      int n;
      act_in = 0; act_out = 0; act_cstall = 0; act_done = 0;
      cycle(1'b1, c, ni, no);
      n = 0;
      while (phase != P_IDLE && n < 40000) begin
         cycle($urandom_range(0, 7) == 0, 8'($urandom),
               int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
         n++;
      end
      check("txn_timeout", 64'(phase != P_IDLE), 64'h0);
      if (phase != P_IDLE) apply_reset();
      check("in_xfers",    64'(act_in),     64'(ni));
      check("out_xfers",   64'(act_out),    64'(no));
      check("cmd_stalls",  64'(act_cstall), 64'(hold));
      check("done_pulses", 64'(act_done),   64'h1);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0; start_cmd = '0; in_words = '0; out_words = '0;
      cmd_canReceive = 1'b0; in_canReceive = 1'b0; out_isReady = 1'b0;
      sink_canReceive = 1'b0; src_isReady = 1'b0;
      src_data = SRC_BASE; out = OUT_BASE;
      #1 check_idle_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // command held off for 3 cycles, input-only transfer
      mode = 0; pct = 0; hold = 3;
      run_txn(8'h05, 4, 0);

      // single word each way: byte reversal on both paths
      hold = 0;
      run_txn(8'hA3, 1, 1);

      // main emits output before taking the remaining input
      mode = 1;
      run_txn(8'h3C, 3, 2);

      // empty transaction
      mode = 0;
      run_txn(8'h7E, 0, 0);

      // long randomly stalled transfer
      pct = 25;
      run_txn(8'h5A, 2688, 2688);

      // a few small random transactions
      for (int i = 0; i < 4; i++) begin
         pct  = int'($urandom_range(0, 60));
         hold = int'($urandom_range(0, 3));
         run_txn(8'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      end

      // asynchronous reset in the middle of streaming
      pct = 30; hold = 0;
      act_done = 0;
      cycle(1'b1, 8'hC7, 50, 50);
      for (int n = 0; n < 2000 && !(phase == P_STREAM && in_sent >= 5); n++) begin
         cycle(1'b0, 8'h00, 0, 0);
      end
      check("reached_stream", 64'(phase), 64'(P_STREAM));
      apply_reset();
      check("abort_no_done", 64'(act_done), 64'h0);

      // fresh transaction after the abort
      run_txn(8'h11, 20, 15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/main_host_sequencer.md
Name: main_host_sequencer

Overview:
- Hardware initiator for the `main` command/in/out stream protocol; this is the host side of the interface that `main` responds on.
- Issues one command word to `main`, then streams a programmed number of 64-bit input words from a source port into `main` and drains a programmed number of output words from `main` to a sink port.
- Used by on-chip test harnesses and SoC glue in place of a software host.

Parameters:
- CMD_W, 8, width of the command word (set to `MainCMD_SIZE at instantiation).
- CNT_W, 14, width of the word counters; covers the largest decaps input, 8098 words.
- SWAP_BYTES, 1, when 1 reverse byte order of every 64-bit word on both the src->in and out->sink paths.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transaction.
- start_cmd  in  CMD_W  command captured on start.
- in_words  in  CNT_W  number of words to send to main; captured on start.
- out_words  in  CNT_W  number of words to take from main; captured on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- cmd  out  CMD_W  command to main.
- cmd_isReady  out  1  command valid.
- cmd_canReceive  in  1  main accepts command.
- in  out  64  data word to main.
- in_isReady  out  1  data word valid.
- in_canReceive  in  1  main accepts data word.
- out  in  64  data word from main.
- out_isReady  in  1  main data word valid.
- out_canReceive  out  1  sequencer accepts main data word.
- src_data  in  64  source word.
- src_isReady  in  1  source word valid.
- src_canReceive  out  1  source word consumed.
- sink_data  out  64  word to sink.
- sink_isReady  out  1  sink word valid.
- sink_canReceive  in  1  sink accepts word.

Behaviour:
- Transfer on any channel occurs in a cycle where isReady and canReceive are both high at the rising clock edge.
- Reset (rst=0, asynchronous): state=IDLE, both counters=0, cmd register=0, busy=0, done=0.
  - All isReady/canReceive outputs are 0 during reset; cmd output is 0.
  - Reset mid-transaction abandons it with no done pulse.
- IDLE: on start=1, register start_cmd, in_words, out_words; go to CMD. busy=1 from the next cycle.
- CMD: cmd_isReady=1 and cmd holds the registered value until accepted.
  - cmd_isReady must not drop before acceptance.
  - On transfer go to STREAM. Minimum one cycle in CMD.
- STREAM: input and output run concurrently, so main may emit output before all input is consumed without deadlock.
  - Input path (combinational): in=swap(src_data); in_isReady=src_isReady&(in_rem!=0); src_canReceive=in_canReceive&(in_rem!=0). in_rem decrements on each in transfer.
  - Output path (combinational): sink_data=swap(out); sink_isReady=out_isReady&(out_rem!=0); out_canReceive=sink_canReceive&(out_rem!=0). out_rem decrements on each sink transfer.
  - When in_rem=0 and out_rem=0 at a clock edge, go to DONE. A transfer that brings the last counter to 0 moves state on the following edge.
  - A zero-count direction is complete immediately. With in_words=0 and out_words=0, STREAM lasts one cycle.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- start while busy is ignored. Parameters are not re-sampled.
- No data buffering: zero-latency pass-through, zero storage. Counters never wrap; decrement is gated by rem!=0.
- Outside STREAM, in/src/out/sink handshake outputs are all 0. in and sink_data may show don't-care data.
- swap(): byte k of result = byte 7-k of input when SWAP_BYTES=1, else identity.

Test Plan:
- start_cmd=0x05, in_words=4, out_words=0; cmd_canReceive held low 3 cycles.
  -> cmd_isReady stays 1 with cmd=0x05 for those 3 cycles, then 4 in transfers, then done pulse.
- src_data=0x0102030405060708, SWAP_BYTES=1.
  -> in=0x0807060504030201. out=0x1122334455667788 -> sink_data=0x8877665544332211.
- in_words=3, out_words=2; main raises out_isReady after the first input word.
  -> both output words pass while input is still pending; done only after all 5 transfers complete.
- in_words=0, out_words=0.
  -> sequence is cmd transfer, one STREAM cycle, done; no in/out handshake asserted.
- Random stalls on src_isReady/in_canReceive/sink_canReceive over in_words=2688, out_words=2688.
  -> exactly 2688 transfers each way, order preserved, no extra transfer after count reaches 0.
- rst driven low mid-STREAM, async between edges.
  -> all handshake outputs 0 immediately, busy=0, no done pulse; a fresh start afterwards runs a clean transaction.
